// File: rtl/hex_scan_driver.sv
// ---------------------------------------------------------------------------
// hex_scan_driver
//
// Time-multiplexes four 7-segment digits onto one shared segment bus.
// Each frame is four equal slots of SCAN_DIV clocks, one per digit. A slot
// opens with DEAD_CYCLES blank clocks so that segment ghosting from the
// previous digit cannot appear. The digit is then lit for a
// brightness-dependent on-length, and the slot finishes blank.
// The digit patterns and the brightness code are captured once per frame.
// This keeps a frame internally consistent even if the hex controller
// updates its outputs mid-scan.
//
// Parameters
//   SCAN_DIV     clk cycles per digit slot
//   DEAD_CYCLES  blank cycles at the start of every slot (>= 1)
//
// Ports
//   clk          clock, all logic on the rising edge
//   reset        synchronous, active-high reset
//   en           scan enable; low forces all digits off and parks in IDLE
//   hex0..hex3   active-low segment patterns, one per digit
//   bright       brightness code, 0 = dimmest, 15 = full
//   seg          registered shared active-low segment bus
//   an           registered active-low digit enables, an[i] selects digit i
//   frame_start  registered one-cycle pulse on cycle 0 of every frame
// ---------------------------------------------------------------------------
module hex_scan_driver #(
    parameter int SCAN_DIV    = 50000,
    parameter int DEAD_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [6:0] hex0,
    input  logic [6:0] hex1,
    input  logic [6:0] hex2,
    input  logic [6:0] hex3,
    input  logic [3:0] bright,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       frame_start
);

    localparam int              SW        = $clog2(SCAN_DIV);
    localparam int              ACTIVE    = SCAN_DIV - DEAD_CYCLES;
    localparam logic [SW-1:0]   SLOT_LAST = SW'(SCAN_DIV - 1);
    localparam logic [31:0]     DEAD_W    = 32'(DEAD_CYCLES);

    // The blank lead-in of every slot is what guarantees a blank cycle
    // between digits. The on-length formula also needs enough active room
    // so that the dimmest setting still lights for at least one cycle.
    if ((SCAN_DIV - DEAD_CYCLES) < 16 || DEAD_CYCLES < 1) begin : g_bad_params
        $error("hex_scan_driver: need DEAD_CYCLES >= 1 and SCAN_DIV - DEAD_CYCLES >= 16");
    end

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        ON,
        OFF
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [SW-1:0] slot;
    logic [SW-1:0] slot_nx;
    logic [1:0]    digit;
    logic [1:0]    digit_nx;
    logic          frame_begin;

    logic [6:0]    shadow [4];
    logic [3:0]    bright_lat;
    logic [31:0]   on_len;

    logic [6:0]    seg_nx;
    logic [3:0]    an_nx;

    // On-length of the lit phase, scaled from the active part of the slot in
    // sixteenths. It uses the latched code so that it stays fixed for the
    // whole frame. Full brightness yields exactly ACTIVE, so the slot then
    // has no OFF tail.
    assign on_len = (32'(ACTIVE) * ({28'd0, bright_lat} + 32'd1)) >> 4;

    // Next-state logic.
    // A disable always wins and parks the scanner at the start of a frame.
    // Leaving IDLE, or wrapping past digit 3, produces frame cycle 0.
    // Inside a slot, the phase follows directly from where the next slot
    // count lands relative to the dead time and the on-length.
    always_comb begin
        state_nx    = state;
        slot_nx     = slot;
        digit_nx    = digit;
        frame_begin = 1'b0;

        if (!en) begin
            state_nx = IDLE;
            slot_nx  = '0;
            digit_nx = '0;
        end else if (state == IDLE) begin
            state_nx    = BLANK;
            slot_nx     = '0;
            digit_nx    = '0;
            frame_begin = 1'b1;
        end else if (slot == SLOT_LAST) begin
            state_nx    = BLANK;
            slot_nx     = '0;
            digit_nx    = digit + 2'd1;
            frame_begin = (digit == 2'd3);
        end else begin
            slot_nx = slot + SW'(1);
            if (32'(slot_nx) < DEAD_W) begin
                state_nx = BLANK;
            end else if (32'(slot_nx) < (DEAD_W + on_len)) begin
                state_nx = ON;
            end else begin
                state_nx = OFF;
            end
        end
    end

    // Output values for the coming cycle.
    // They are built from the next state so that the registered outputs line
    // up with the state they describe. Only ON drives a digit; every other
    // state is fully blank.
    always_comb begin
        seg_nx = 7'h7F;
        an_nx  = 4'hF;
        if (state_nx == ON) begin
            an_nx  = ~(4'b0001 << digit_nx);
            seg_nx = shadow[digit_nx];
        end
    end

    // State register for the scan FSM and its slot and digit counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            slot  <= '0;
            digit <= '0;
        end else begin
            state <= state_nx;
            slot  <= slot_nx;
            digit <= digit_nx;
        end
    end

    // Registered outputs and the per-frame snapshot of the inputs.
    // The snapshot is taken on the edge that enters frame cycle 0. The
    // frame's first lit cycle is at least one dead cycle later, so it always
    // sees the new patterns.
    always_ff @(posedge clk) begin
        if (reset) begin
            seg         <= 7'h7F;
            an          <= 4'hF;
            frame_start <= 1'b0;
            shadow[0]   <= 7'h7F;
            shadow[1]   <= 7'h7F;
            shadow[2]   <= 7'h7F;
            shadow[3]   <= 7'h7F;
            bright_lat  <= 4'd0;
        end else begin
            seg         <= seg_nx;
            an          <= an_nx;
            frame_start <= frame_begin;
            if (frame_begin) begin
                shadow[0]  <= hex0;
                shadow[1]  <= hex1;
                shadow[2]  <= hex2;
                shadow[3]  <= hex3;
                bright_lat <= bright;
            end
        end
    end

endmodule

// File: doc/hex_scan_driver.md
HEX_SCAN_DRIVER -- requirements
Module: hex_scan_driver

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, giving clk cycles per digit slot.
REQ-002 SHALL have parameter DEAD_CYCLES, default 16, giving blank cycles at the start of each slot.
REQ-003 SHALL have port clk  input  1  clock; all logic on posedge.
REQ-004 SHALL have port reset  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port en  input  1  scan enable; 0 forces all digits off.
REQ-006 SHALL have ports hex0..hex3  input  7 each  active-low segment patterns from the hex controller, one per digit.
REQ-007 SHALL have port bright  input  4  brightness code, 0 = dimmest, 15 = full.
REQ-008 SHALL have port seg  output  7  shared active-low segment bus.
REQ-009 SHALL have port an  output  4  active-low digit enables; an[i] selects digit i.
REQ-010 SHALL have port frame_start  output  1  one-cycle pulse on cycle 0 of each frame.

Function
REQ-011 SHALL require SCAN_DIV - DEAD_CYCLES >= 16; slot counter width = clog2(SCAN_DIV).
REQ-012 SHALL implement states IDLE, BLANK, ON, OFF, plus a slot counter (0..SCAN_DIV-1) and a digit index (0..3).
REQ-013 SHALL, in IDLE with en=1, enter BLANK with digit=0 and slot=0 on the next cycle; that cycle is frame cycle 0.
REQ-014 SHALL, on frame cycle 0, latch hex0..hex3 into shadow regs and bright into bright_lat, and assert frame_start for exactly that cycle.
REQ-015 SHALL compute on-length L = ((SCAN_DIV - DEAD_CYCLES) * (bright_lat + 1)) >> 4, truncating, giving L >= 1.
REQ-016 SHALL drive blank output (an=4'hF, seg=7'h7F) during slot cycles 0..DEAD_CYCLES-1 (BLANK).
REQ-017 SHALL, during slot cycles DEAD_CYCLES..DEAD_CYCLES+L-1 (ON), drive an with only bit[digit] low and seg = shadow[digit].
REQ-018 SHALL drive blank output in OFF for the remaining cycles of the slot; when L fills the slot, OFF is skipped.
REQ-019 SHALL, at slot=SCAN_DIV-1, wrap slot to 0, increment digit modulo 4, and enter BLANK.
REQ-020 SHALL, on the digit 3->0 wrap, start a new frame: re-latch per REQ-014 and pulse frame_start.
REQ-021 SHALL make frame length exactly 4*SCAN_DIV cycles, with frame_start pulses spaced exactly that far apart.
REQ-022 SHALL ignore hex0..3 and bright changes mid-frame; they take effect only at the next frame cycle 0.
REQ-023 SHALL, when en=0 is sampled in any state, enter IDLE on the next cycle with blank outputs, slot=0, digit=0, frame_start=0.
REQ-024 SHALL, on re-enable, restart at digit 0 with a fresh latch and no partial-frame resume.
REQ-025 SHALL never assert more than one an bit low in any cycle, and SHALL never change an and seg to a new digit without an intervening blank cycle (DEAD_CYCLES >= 1).
REQ-026 SHALL register seg, an and frame_start, with no combinational path from inputs to outputs.

Reset
REQ-027 SHALL, while reset=1, force state=IDLE, slot=0, digit=0, seg=7'h7F, an=4'hF, frame_start=0, shadow regs=7'h7F and bright_lat=0.
REQ-028 SHALL give reset priority over en, including mid-ON; outputs are blank on the cycle after reset is sampled.
REQ-029 SHALL, after reset deasserts with en=1, produce frame cycle 0 per REQ-013.

Verification (SCAN_DIV=40, DEAD_CYCLES=8, so L=2*(bright+1))
REQ-030 SHALL cover full brightness: bright=15, hex0..3=40,79,24,30, en=1 -> per slot, 8 blank then 32 on; an cycles E,D,B,7; seg matches the digit; frame_start every 160 cycles.
REQ-031 SHALL cover minimum brightness: bright=0 -> per slot, 8 blank, 2 on, 30 blank; count exactly 2 active cycles per digit.
REQ-032 SHALL cover mid-frame update: change hex2 to 12 and bright to 3 during digit 1 -> the current frame shows the old value; from the next frame, digit 2 shows 12 with L=8.
REQ-033 SHALL cover disable mid-ON: drop en at slot 20 of digit 2 -> blank next cycle; re-raise en -> frame_start on the following cycle, digit 0 first.
REQ-034 SHALL cover reset mid-ON: assert reset 1 cycle during digit 1 ON -> an=F, seg=7F, frame_start=0 next cycle; on release with en=1, a new frame starts.
REQ-035 SHALL include a continuous checker: at most one an bit low, and a blank cycle separates every digit change.
